// File: rtl/dynode_event_fifo.sv
// dynode_event_fifo
// Timestamps rising edges of the dynode trigger flag and queues {timestamp, offset}
// entries in a small FIFO that software drains over the register bus.
// Register map (word offsets from BASE):
//   0 CTRL     RW  bit0 enable, bit1 clear strobe (reads 0)
//   1 STATUS   RO  {5'b0, overflow, full, empty, 3'b0, count[4:0]}
//   2 HEAD_TS  RO  timestamp of oldest entry, 0 when empty
//   3 HEAD_OFF RO  {10'b0, offset} of oldest entry, 0 when empty
//   4 POP      WO  any write removes the head entry, reads 0
//   5 DROPCNT  RO  saturating count of events lost to a full FIFO
module dynode_event_fifo #(
  parameter logic [15:0] BASE = 16'h0010,
  parameter int          AW   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [33:0] ibus,
  output logic [15:0] obus,
  input  logic        single,
  input  logic [5:0]  offset,
  output logic        nonempty
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  // Register bus fields; the clock bit carried in the bus is not used, port clk is
  logic        busWr;
  logic [15:0] busAddr;
  logic [15:0] busData;
  logic [15:0] relAddr;
  logic        inRange;
  logic        unusedBits;

  assign busWr      = ibus[32];
  assign busAddr    = ibus[31:16];
  assign busData    = ibus[15:0];
  assign unusedBits = ^{ibus[33], busData[15:2]};

  // Offset-relative decode also behaves sensibly if BASE sits near the top of the map
  assign relAddr = busAddr - BASE;
  assign inRange = (relAddr < 16'd6);

  logic wrCtrl;
  logic clearReq;
  logic popReq;

  assign wrCtrl   = busWr && (relAddr == 16'd0);
  assign clearReq = wrCtrl && busData[1];
  assign popReq   = busWr && (relAddr == 16'd4);

  // State
  logic [15:0]   timestamp;
  logic          enable;
  logic          singleDly;
  logic          overflow;
  logic [15:0]   dropCnt;
  logic [AW:0]   count;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [21:0]   mem [DEPTH];

  logic isFull;
  logic isEmpty;
  logic trigEvent;
  logic doPop;
  logic doPush;
  logic doDrop;

  assign isFull  = (count == FULL_COUNT);
  assign isEmpty = (count == '0);

  // A held-high trigger produces a single event because only the 0->1 transition counts
  assign trigEvent = single && !singleDly && enable;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a coincident push.
  // Clear overrides both so that nothing leaks into the freshly emptied FIFO.
  assign doPop  = popReq && !isEmpty && !clearReq;
  assign doPush = trigEvent && (!isFull || doPop) && !clearReq;
  assign doDrop = trigEvent && isFull && !doPop && !clearReq;

  assign nonempty = !isEmpty;

  // Free-running timestamp, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timestamp <= 16'd0;
    end else begin
      timestamp <= timestamp + 16'd1;
    end
  end

  // Control, pointers, occupancy and drop bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable    <= 1'b0;
      singleDly <= 1'b0;
      overflow  <= 1'b0;
      dropCnt   <= 16'd0;
      count     <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
    end else begin
      singleDly <= single;
      if (wrCtrl) begin
        enable <= busData[0];
      end
      if (clearReq) begin
        overflow <= 1'b0;
        dropCnt  <= 16'd0;
        count    <= '0;
        wrPtr    <= '0;
        rdPtr    <= '0;
      end else begin
        if (doPush) begin
          wrPtr <= wrPtr + 1'b1;
        end
        if (doPop) begin
          rdPtr <= rdPtr + 1'b1;
        end
        if (doPush && !doPop) begin
          count <= count + 1'b1;
        end else if (doPop && !doPush) begin
          count <= count - 1'b1;
        end
        if (doDrop) begin
          overflow <= 1'b1;
          if (dropCnt != 16'hFFFF) begin
            dropCnt <= dropCnt + 16'd1;
          end
        end
      end
    end
  end

  // Entry storage; contents are never reset, visibility is governed by count alone
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= {timestamp, offset};
    end
  end

  // Register read multiplexer
  logic [21:0] headEntry;
  logic [4:0]  countField;
  logic [15:0] rdData;

  assign headEntry  = isEmpty ? 22'd0 : mem[rdPtr];
  assign countField = 5'(count);

  always_comb begin
    rdData = 16'd0;
    case (relAddr[2:0])
      3'd0:    rdData = {15'd0, enable};
      3'd1:    rdData = {5'd0, overflow, isFull, isEmpty, 3'd0, countField};
      3'd2:    rdData = headEntry[21:6];
      3'd3:    rdData = {10'd0, headEntry[5:0]};
      3'd5:    rdData = dropCnt;
      default: rdData = 16'd0;
    endcase
  end

  assign obus = inRange ? rdData : 16'bz;

endmodule

// File: tb/tb_dynode_event_fifo.sv
// tb_dynode_event_fifo
// Directed scenarios followed by randomized traffic, checked against a queue-based
// reference model. Register reads push expected values into a scoreboard queue;
// a monitor on the falling edge pops and compares whatever the DUT presents.
module tb_dynode_event_fifo;

  localparam logic [15:0] BASE  = 16'h0010;
  localparam int          AW    = 4;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [33:0] ibus = '0;
  wire  [15:0] obus;
  logic        single = 1'b0;
  logic [5:0]  offset = '0;
  logic        nonempty;

  always #5 clk = ~clk;

  dynode_event_fifo #(.BASE(BASE), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .ibus     (ibus),
    .obus     (obus),
    .single   (single),
    .offset   (offset),
    .nonempty (nonempty)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic        ne;
  } exp_t;

  exp_t expQ[$];
  logic readReq = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state: the FIFO is literally a queue of {timestamp, offset}
  logic [21:0] mQ[$];
  bit          mEn;
  bit          mOvf;
  bit          mPrev;
  int          mDrop;
  logic [15:0] mTs;

  function automatic string regName(input logic [15:0] a);
    case (a - BASE)
      16'd0:   return "CTRL";
      16'd1:   return "STATUS";
      16'd2:   return "HEAD_TS";
      16'd3:   return "HEAD_OFF";
      16'd4:   return "POP";
      16'd5:   return "DROPCNT";
      default: return "OTHER";
    endcase
  endfunction

  function automatic logic [15:0] expRead(input logic [15:0] a);
    int         n;
    logic [4:0] c;
    logic [21:0] h;
    n = mQ.size();
    c = 5'(n);
    h = (n > 0) ? mQ[0] : 22'd0;
    case (a - BASE)
      16'd0:   return {15'd0, mEn};
      16'd1:   return {5'd0, mOvf, (n == DEPTH), (n == 0), 3'd0, c};
      16'd2:   return h[21:6];
      16'd3:   return {10'd0, h[5:0]};
      16'd5:   return 16'(mDrop);
      default: return 16'd0;
    endcase
  endfunction

  task automatic modelReset();
    mQ.delete();
    mEn   = 0;
    mOvf  = 0;
    mPrev = 0;
    mDrop = 0;
    mTs   = 16'd0;
  endtask

  // One clock edge of the reference behaviour, given the inputs held during the cycle
  task automatic modelStep(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                           input bit sng, input logic [5:0] off);
    bit evt;
    evt = sng && !mPrev && mEn;
    if (wr && addr == BASE && data[1]) begin
      mQ.delete();
      mOvf  = 0;
      mDrop = 0;
    end else begin
      if (wr && addr == BASE + 16'd4 && mQ.size() > 0) void'(mQ.pop_front());
      if (evt) begin
        if (mQ.size() < DEPTH) begin
          mQ.push_back({mTs, off});
        end else begin
          mOvf = 1;
          if (mDrop < 65535) mDrop++;
        end
      end
    end
    if (wr && addr == BASE) mEn = data[0];
    mPrev = sng;
    mTs   = mTs + 16'd1;
  endtask

  task automatic pushRead(input logic [15:0] a);
    exp_t e;
    e.addr = a;
    e.data = expRead(a);
    e.ne   = (mQ.size() != 0);
    expQ.push_back(e);
  endtask

  // Called at posedge+1: drive one cycle of inputs, then advance across the next edge
  task automatic applyStimulus(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                               input bit sng, input logic [5:0] off, input bit rd);
    ibus   = {1'($urandom_range(0, 1)), wr, addr, data};
    single = sng;
    offset = off;
    if (rd && !wr) begin
      pushRead(addr);
      readReq = 1'b1;
    end else begin
      readReq = 1'b0;
    end
    @(posedge clk);
    if (reset) modelStep(wr, addr, data, sng, off);
    #1;
  endtask

  task automatic readReg(input int idx, input bit sng);
    applyStimulus(0, BASE + 16'(idx), 16'd0, sng, 6'd0, 1);
  endtask

  task automatic writeReg(input int idx, input logic [15:0] d, input bit sng, input logic [5:0] off);
    applyStimulus(1, BASE + 16'(idx), d, sng, off, 0);
  endtask

  // Two cycles: rising trigger, then trigger low while reading STATUS
  task automatic genEvent(input logic [5:0] off);
    applyStimulus(0, BASE + 16'd5, 16'd0, 1, off, 1);
    readReg(1, 0);
  endtask

  task automatic popWithHeadCheck();
    readReg(2, 0);
    readReg(3, 0);
    writeReg(4, 16'h0001, 0, 6'd0);
  endtask

  // Reset asserted between clock edges, STATUS read before the next edge
  task automatic midReset();
    ibus    = {1'b0, 1'b0, BASE + 16'd1, 16'd0};
    single  = 1'b0;
    readReq = 1'b0;
    #2;
    reset = 1'b0;
    modelReset();
    pushRead(BASE + 16'd1);
    readReq = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever a read is presented, compare bus data and nonempty to the scoreboard
  always @(negedge clk) begin
    if (readReq) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: read presented with no expectation queued");
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput(regName(e.addr), obus, e.data);
        checkOutput("nonempty", {15'd0, nonempty}, {15'd0, e.ne});
      end
    end
  end

  initial begin
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state
    readReg(0, 0);
    readReg(1, 0);
    readReg(2, 0);
    readReg(3, 0);
    readReg(5, 0);

    // Single event with offset 17, visible one cycle later
    writeReg(0, 16'h0001, 0, 6'd0);
    applyStimulus(0, BASE + 16'd1, 16'd0, 1, 6'd17, 1);
    readReg(1, 0);
    readReg(2, 0);
    readReg(3, 0);
    writeReg(4, 16'h0000, 0, 6'd0);

    // Held-high trigger captures once
    for (int i = 0; i < 10; i++) applyStimulus(0, BASE + 16'd1, 16'd0, 1, 6'(i + 3), 1);
    readReg(1, 0);
    popWithHeadCheck();
    readReg(1, 0);

    // Overflow: 18 events into 16 slots, then drain in order
    for (int i = 0; i < 18; i++) genEvent(6'(i + 40));
    readReg(1, 0);
    readReg(5, 0);
    for (int i = 0; i < 16; i++) popWithHeadCheck();
    readReg(1, 0);
    // POP while empty is ignored
    writeReg(4, 16'h0000, 0, 6'd0);
    readReg(1, 0);

    // Full FIFO with a coincident event and pop
    writeReg(0, 16'h0003, 0, 6'd0);
    for (int i = 0; i < 16; i++) genEvent(6'(i));
    writeReg(4, 16'h0000, 1, 6'd63);
    readReg(1, 0);
    readReg(5, 0);
    for (int i = 0; i < 16; i++) popWithHeadCheck();

    // Empty FIFO with a coincident event and pop
    writeReg(4, 16'h0000, 1, 6'd9);
    readReg(1, 0);
    readReg(3, 0);

    // Clear wins over a coincident event
    for (int i = 0; i < 17; i++) genEvent(6'(i + 20));
    for (int i = 0; i < 11; i++) writeReg(4, 16'h0000, 0, 6'd0);
    readReg(1, 0);
    readReg(5, 0);
    writeReg(0, 16'h0003, 1, 6'd5);
    readReg(0, 0);
    readReg(1, 0);
    readReg(5, 0);

    // Asynchronous reset with entries queued
    for (int i = 0; i < 3; i++) genEvent(6'(i + 1));
    readReg(1, 0);
    midReset();
    readReg(1, 0);
    readReg(2, 0);
    readReg(0, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) genEvent(6'(i + 7));
    readReg(1, 0);
    readReg(5, 0);

    // Randomized traffic
    writeReg(0, 16'h0001, 0, 6'd0);
    for (int i = 0; i < 3000; i++) begin
      int  op;
      bit  sng;
      logic [5:0] off;
      op  = $urandom_range(0, 99);
      sng = ($urandom_range(0, 2) == 0);
      off = 6'($urandom);
      if (op < 2) begin
        writeReg(0, 16'(($urandom_range(0, 3) == 0) ? 3 : 1), sng, off);
      end else if (op < 4) begin
        writeReg(0, 16'($urandom_range(0, 1)), sng, off);
      end else if (op < 30) begin
        writeReg(4, 16'($urandom), sng, off);
      end else begin
        applyStimulus(0, BASE + 16'($urandom_range(0, 5)), 16'd0, sng, off, 1);
      end
    end
    readReg(1, 0);
    readReg(5, 0);

    readReq = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 16'(expQ.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dynode_event_fifo.md
DYNODE_EVENT_FIFO -- requirements
Module: dynode_event_fifo

Interface
REQ-001 Parameter BASE, default 16'h0010: base register-bus address; block occupies BASE..BASE+5.
REQ-002 Parameter AW, default 4: FIFO address width; DEPTH = 2**AW entries.
REQ-003 Port clk  input  1: sole clock; all state updates on posedge clk.
REQ-004 Port reset  input  1: asynchronous, active-low reset; 0 = in reset.
REQ-005 Port ibus  input  34: register bus {clk, wr, addr[15:0], wrdata[15:0]}; the embedded clk bit shall be ignored in favour of port clk.
REQ-006 Port obus  output  16: register read data; 16'bz when addr is outside BASE..BASE+5.
REQ-007 Port single  input  1: trigger flag from the upstream dynode trigger stage.
REQ-008 Port offset  input  6: sub-sample time offset accompanying single.
REQ-009 Port nonempty  output  1: high while FIFO count > 0.

Function
REQ-010 A 16-bit free-running timestamp counter shall increment every clk cycle, wrapping 16'hFFFF -> 0.
REQ-011 An event is a rising edge of single (single=1 and single delayed one cycle = 0) while CTRL.enable=1; a held-high single yields exactly one event.
REQ-012 On an event, entry {timestamp, offset} shall be sampled in the edge cycle and visible at the FIFO head/count on the next cycle (1-cycle latency).
REQ-013 Registers: BASE+0 CTRL RW (bit0 enable; bit1 clear strobe, reads 0); BASE+1 STATUS RO; BASE+2 HEAD_TS RO; BASE+3 HEAD_OFF RO {10'b0, offset}; BASE+4 POP write-strobe, reads 0; BASE+5 DROPCNT RO.
REQ-014 STATUS = {5'b0, overflow[10], full[9], empty[8], 3'b0, count[4:0]}; count range 0..DEPTH.
REQ-015 HEAD_TS and HEAD_OFF shall read the oldest entry; when empty they shall read 0.
REQ-016 Any bus write to BASE+4 shall remove the head entry on that clk edge if count > 0; ignored when empty.
REQ-017 Event when full with no same-cycle pop: entry discarded, overflow sticky set, DROPCNT incremented, saturating at 16'hFFFF.
REQ-018 Event and pop in the same cycle when full: pop and push both performed, count unchanged, no drop.
REQ-019 Event and pop in the same cycle when empty: push performed, pop ignored, count becomes 1.
REQ-020 Event and pop in the same cycle when 0 < count < DEPTH: count unchanged, head advances.
REQ-021 Write to CTRL with bit1=1: count, pointers, overflow and DROPCNT shall clear on that edge; clear takes priority over a same-cycle event or pop; enable takes wrdata bit0 on the same write; timestamp unaffected.
REQ-022 Events with enable=0 shall be ignored and not counted as drops.
REQ-023 Pointers shall wrap modulo DEPTH; full = (count == DEPTH), empty = (count == 0).

Reset
REQ-024 While reset=0: timestamp=0, enable=0, count=0, pointers=0, overflow=0, DROPCNT=0, single-delay register=0, nonempty=0.
REQ-025 Reset assertion mid-operation shall discard all FIFO contents immediately; storage array contents need not clear but shall not be visible (HEAD reads 0).
REQ-026 After reset release, first timestamp increment occurs on the first posedge clk with reset=1.

Verification
REQ-027 Reset release, write CTRL=1, pulse single with offset=6'd17 at timestamp T -> next cycle STATUS count=1, HEAD_TS=T, HEAD_OFF=17, nonempty=1.
REQ-028 Hold single high 10 cycles -> exactly one entry captured.
REQ-029 Issue 18 events with no pops (DEPTH=16) -> count=16, full=1, overflow=1, DROPCNT=2; 16 POP writes return first 16 events in order, then empty=1.
REQ-030 With FIFO full, event coincident with POP write -> count stays 16, DROPCNT unchanged, newest entry appended at tail.
REQ-031 With 5 entries and overflow=1, write CTRL=16'h0003 coincident with an event -> count=0, overflow=0, DROPCNT=0, enable=1.
REQ-032 Drive reset=0 asynchronously between clk edges with 3 entries queued -> STATUS reads count=0, empty=1 immediately; events with enable=0 after release leave count=0.
